nios_system_v_out_ctrl: RTL and testbench

//   Avalon-MM slave output port for the video control path; the write-side

---
 rtl/nios_system_v_out_ctrl.sv | 142 ++++++++++++++
 tb/tb_nios_system_v_out_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/nios_system_v_out_ctrl.sv
// Avalon-MM video control output port: data, atomic set/clear and a one-shot pulse engine.
// Optional register readback is built when V_OUT_READBACK_EN is defined; otherwise readdata is tied to 0.
module nios_system_v_out_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  chipselect,
  input  logic [1:0]            address,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_PULSE = 1'b1
  } state_e;

  localparam logic [1:0] ADDR_DATA  = 2'd0;
  localparam logic [1:0] ADDR_PULSE = 2'd1;
  localparam logic [1:0] ADDR_SET   = 2'd2;
  localparam logic [1:0] ADDR_CLEAR = 2'd3;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q,  data_d;
  logic [DATA_WIDTH-1:0] mask_q,  mask_d;
  logic [CNT_WIDTH-1:0]  cnt_q,   cnt_d;

  logic                  wr;
  logic [DATA_WIDTH-1:0] wd;
  logic [CNT_WIDTH-1:0]  wcnt;
  logic                  pulse_on;
  logic                  unused_wd;

  assign wr        = chipselect & ~write_n;
  assign wd        = writedata[DATA_WIDTH-1:0];
  assign wcnt      = writedata[16 +: CNT_WIDTH];
  assign pulse_on  = (state_q == ST_PULSE);
  assign unused_wd = &{1'b0, writedata};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
    end
  end

  // Pulse bookkeeping is resolved first so that a bus write in the same cycle lands on top of it.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;

    if (state_q == ST_PULSE) begin
      if (cnt_q == CNT_ONE) begin
        state_d = ST_IDLE;
        data_d  = data_q & ~mask_q;
        cnt_d   = '0;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end

    if (wr) begin
      case (address)
        ADDR_DATA: begin
          data_d = wd;
        end
        ADDR_PULSE: begin
          // A new pulse aborts the running one and drops its bits from the data register.
          if (state_q == ST_PULSE) begin
            data_d = data_q & ~mask_q;
          end
          mask_d = wd;
          if (wcnt != '0) begin
            state_d = ST_PULSE;
            cnt_d   = wcnt;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        ADDR_SET: begin
          data_d = data_d | wd;
        end
        ADDR_CLEAR: begin
          data_d = data_d & ~wd;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_out
    assign out_port[gi] = data_q[gi] | (pulse_on & mask_q[gi]);
  end

`ifdef V_OUT_READBACK_EN
  logic [31:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = '0;
    case (address)
      ADDR_DATA: begin
        rdata_d[0 +: DATA_WIDTH] = data_q;
      end
      ADDR_PULSE: begin
        rdata_d[16 +: CNT_WIDTH] = cnt_q;
        rdata_d[0 +: DATA_WIDTH] = mask_q;
      end
      default: begin
        rdata_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign readdata = rdata_q;
`else
  assign readdata = '0;
`endif

endmodule

// File: tb/tb_nios_system_v_out_ctrl.sv
// Directed bench for nios_system_v_out_ctrl: bus writes at the falling edge, outputs sampled at the falling edge.
module tb_nios_system_v_out_ctrl;

`ifdef V_OUT_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        chipselect;
  logic [1:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [15:0] out_port;

  int n_vec;
  int n_err;

  nios_system_v_out_ctrl #(
    .DATA_WIDTH(16),
    .CNT_WIDTH (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .chipselect(chipselect),
    .address   (address),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_rd(input logic [1:0] a);
    address = a;
    @(negedge clk);
  endtask

  function automatic logic [31:0] rb(input logic [31:0] v);
    return RB ? v : 32'h0;
  endfunction

  initial begin
    n_vec      = 0;
    n_err      = 0;
    reset      = 1'b1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = 32'h0;
    repeat (2) tick();
    check("reset_out", {16'h0, out_port}, 32'h0);
    check("reset_rd", readdata, 32'h0);
    reset = 1'b0;
    tick();

    // Reset in the middle of a long pulse.
    bus_wr(2'd1, 32'h0064_00FF);
    check("t1_pulse_on", {16'h0, out_port}, 32'h0000_00FF);
    repeat (10) tick();
    check("t1_after10", {16'h0, out_port}, 32'h0000_00FF);
    check("t1_rd_cnt", readdata, rb(32'h005B_00FF));
    #2 reset = 1'b1;
    #1;
    check("t1_rst_out", {16'h0, out_port}, 32'h0);
    check("t1_rst_rd", readdata, 32'h0);
    tick();
    reset = 1'b0;
    repeat (3) tick();
    check("t1_post_out", {16'h0, out_port}, 32'h0);
    check("t1_post_rd", readdata, 32'h0);

    // Data, set, clear.
    bus_wr(2'd0, 32'h0000_1234);
    check("t2_data", {16'h0, out_port}, 32'h0000_1234);
    bus_wr(2'd2, 32'h0000_0F00);
    check("t2_set", {16'h0, out_port}, 32'h0000_1F34);
    bus_wr(2'd3, 32'h0000_0004);
    check("t2_clear", {16'h0, out_port}, 32'h0000_1F30);
    bus_rd(2'd0);
    check("t2_rd_data", readdata, rb(32'h0000_1F30));

    // Three-cycle pulse.
    bus_wr(2'd0, 32'h0);
    bus_wr(2'd1, 32'h0003_8001);
    check("t3_cyc1", {16'h0, out_port}, 32'h0000_8001);
    tick();
    check("t3_cyc2", {16'h0, out_port}, 32'h0000_8001);
    tick();
    check("t3_cyc3", {16'h0, out_port}, 32'h0000_8001);
    tick();
    check("t3_end", {16'h0, out_port}, 32'h0);
    bus_rd(2'd0);
    check("t3_rd_data", readdata, 32'h0);
    bus_rd(2'd1);
    check("t3_rd_pulse", readdata, rb(32'h0000_8001));

    // Zero count loads mask only.
    bus_wr(2'd0, 32'h0000_00AA);
    bus_wr(2'd1, 32'h0000_FFFF);
    check("t4_no_pulse", {16'h0, out_port}, 32'h0000_00AA);
    tick();
    check("t4_still", {16'h0, out_port}, 32'h0000_00AA);
    bus_rd(2'd1);
    check("t4_rd_mask", readdata, rb(32'h0000_FFFF));

    // Pulse restarted mid-flight; SET of an old mask bit is cleared by the abort.
    bus_wr(2'd0, 32'h0);
    bus_wr(2'd1, 32'h0005_0001);
    check("t5_p1", {16'h0, out_port}, 32'h0000_0001);
    tick();
    tick();
    bus_wr(2'd2, 32'h0000_0001);
    check("t5_set_in_pulse", {16'h0, out_port}, 32'h0000_0001);
    bus_wr(2'd1, 32'h0002_0002);
    check("t5_abort", {16'h0, out_port}, 32'h0000_0002);
    tick();
    check("t5_p2_cyc2", {16'h0, out_port}, 32'h0000_0002);
    tick();
    check("t5_end", {16'h0, out_port}, 32'h0);
    bus_rd(2'd0);
    check("t5_rd_data", readdata, 32'h0);

    // Bus write on the terminal cycle wins.
    bus_wr(2'd1, 32'h0004_0010);
    check("t6_p", {16'h0, out_port}, 32'h0000_0010);
    repeat (3) tick();
    bus_wr(2'd0, 32'h0000_0010);
    check("t6_term_wr", {16'h0, out_port}, 32'h0000_0010);
    tick();
    check("t6_after", {16'h0, out_port}, 32'h0000_0010);
    bus_rd(2'd0);
    check("t6_rd_data", readdata, rb(32'h0000_0010));

    // Set during a pulse on a mask bit is removed at pulse end.
    bus_wr(2'd1, 32'h0002_0020);
    bus_wr(2'd2, 32'h0000_0020);
    check("t7_set_in_pulse", {16'h0, out_port}, 32'h0000_0030);
    tick();
    check("t7_end_clear", {16'h0, out_port}, 32'h0000_0010);

    // Writes with chipselect low are ignored.
    chipselect = 1'b0;
    write_n    = 1'b0;
    address    = 2'd0;
    writedata  = 32'h0000_FFFF;
    tick();
    write_n = 1'b1;
    check("t8_cs_low", {16'h0, out_port}, 32'h0000_0010);

    // Maximum count, then abort with a zero-count pulse write.
    bus_wr(2'd1, 32'hFFFF_0000);
    bus_rd(2'd1);
    check("t9_rd_max", readdata, rb(32'hFFFF_0000));
    bus_wr(2'd1, 32'h0);
    bus_rd(2'd1);
    check("t9_rd_abort", readdata, 32'h0);
    check("t9_out", {16'h0, out_port}, 32'h0000_0010);
    bus_rd(2'd2);
    check("t9_rd_addr2", readdata, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
